// File: rtl/sad_min_mv_selector_if.sv
// Candidate/result bundle for the SAD minimum motion-vector selector.
// The master drives search control and candidates; the slave returns per-partition winners.
interface sad_min_mv_selector_if #(
  parameter int NUM_PART = 16,
  parameter int SAD_W    = 16,
  parameter int COL_W    = 5,
  parameter int ROW_W    = 7
);
  logic                      start;
  logic                      abort;
  logic                      sad_valid;
  logic [NUM_PART*SAD_W-1:0] sad_in;
  logic [COL_W-1:0]          col_idx;
  logic [ROW_W-1:0]          row_idx;
  logic                      busy;
  logic                      done;
  logic [NUM_PART*SAD_W-1:0] best_sad;
  logic [NUM_PART*COL_W-1:0] best_col;
  logic [NUM_PART*ROW_W-1:0] best_row;
  logic [COL_W+ROW_W:0]      cand_count;

  modport master (
    output start, abort, sad_valid, sad_in, col_idx, row_idx,
    input  busy, done, best_sad, best_col, best_row, cand_count
  );

  modport slave (
    input  start, abort, sad_valid, sad_in, col_idx, row_idx,
    output busy, done, best_sad, best_col, best_row, cand_count
  );
endinterface

// File: rtl/sad_min_mv_selector.sv
// Tracks the minimum SAD and its (col,row) per partition across one motion search.
// IDLE -> SCAN (accept NUM_CAND candidates) -> DONE (one-cycle done pulse) -> IDLE.
module sad_min_mv_selector #(
  parameter int NUM_PART = 16,
  parameter int SAD_W    = 16,
  parameter int COL_W    = 5,
  parameter int ROW_W    = 7,
  parameter int NUM_CAND = 4096,
  parameter int TIE_LAST = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  sad_min_mv_selector_if.slave  bus
);

  localparam int CNT_W = COL_W + ROW_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CAND);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                    state;
  logic                      busy_q;
  logic                      done_q;
  logic                      first_q;
  logic [CNT_W-1:0]          cand_count_q;
  logic [CNT_W-1:0]          cnt_inc;
  logic [NUM_PART*SAD_W-1:0] best_sad_q;
  logic [NUM_PART*COL_W-1:0] best_col_q;
  logic [NUM_PART*ROW_W-1:0] best_row_q;
  logic [NUM_PART-1:0]       upd;

  assign cnt_inc = cand_count_q + CNT_W'(1);

  // Per-partition replace decision; the first candidate of a search always wins.
  always_comb begin
    // NOTE: default every always_comb output first so no path can infer a latch.
    upd = '0;
    for (int p = 0; p < NUM_PART; p++) begin
      if (first_q)
        upd[p] = 1'b1;
      else if (TIE_LAST != 0)
        upd[p] = bus.sad_in[p*SAD_W +: SAD_W] <= best_sad_q[p*SAD_W +: SAD_W];
      else
        upd[p] = bus.sad_in[p*SAD_W +: SAD_W] <  best_sad_q[p*SAD_W +: SAD_W];
    end
  end

  // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      first_q      <= 1'b0;
      cand_count_q <= '0;
      best_sad_q   <= '1;
      best_col_q   <= '0;
      best_row_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (!bus.abort && bus.start) begin
            state        <= SCAN;
            busy_q       <= 1'b1;
            first_q      <= 1'b1;
            cand_count_q <= '0;
          end
        end

        SCAN: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (bus.sad_valid) begin
            cand_count_q <= cnt_inc;
            first_q      <= 1'b0;
            for (int p = 0; p < NUM_PART; p++) begin
              if (upd[p]) begin
                best_sad_q[p*SAD_W +: SAD_W] <= bus.sad_in[p*SAD_W +: SAD_W];
                best_col_q[p*COL_W +: COL_W] <= bus.col_idx;
                best_row_q[p*ROW_W +: ROW_W] <= bus.row_idx;
              end
            end
            // Results are final on this same edge; done follows one cycle later.
            if (cnt_inc == LAST_CNT) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end

        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.cand_count = cand_count_q;
  assign bus.best_sad   = best_sad_q;
  assign bus.best_col   = best_col_q;
  assign bus.best_row   = best_row_q;

endmodule

// File: tb/tb_sad_min_mv_selector.sv
// Directed bench: two selectors (earliest-tie and latest-tie) share one stimulus stream,
// NUM_PART=2, SAD_W=8, NUM_CAND=4.
module tb_sad_min_mv_selector;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   done_seen = 0;

  always #5 clk = ~clk;

  sad_min_mv_selector_if #(.NUM_PART(2), .SAD_W(8), .COL_W(5), .ROW_W(7)) if_a ();
  sad_min_mv_selector_if #(.NUM_PART(2), .SAD_W(8), .COL_W(5), .ROW_W(7)) if_b ();

  assign if_b.start     = if_a.start;
  assign if_b.abort     = if_a.abort;
  assign if_b.sad_valid = if_a.sad_valid;
  assign if_b.sad_in    = if_a.sad_in;
  assign if_b.col_idx   = if_a.col_idx;
  assign if_b.row_idx   = if_a.row_idx;

  sad_min_mv_selector #(
    .NUM_PART(2), .SAD_W(8), .COL_W(5), .ROW_W(7), .NUM_CAND(4), .TIE_LAST(0)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  sad_min_mv_selector #(
    .NUM_PART(2), .SAD_W(8), .COL_W(5), .ROW_W(7), .NUM_CAND(4), .TIE_LAST(1)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  always @(posedge clk) if (if_a.done === 1'b1) done_seen++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    if_a.start = 1'b1;
    cycle();
    if_a.start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] s0, input logic [7:0] s1,
                      input logic [4:0] c, input logic [6:0] r);
    if_a.sad_valid = 1'b1;
    if_a.sad_in    = {s1, s0};
    if_a.col_idx   = c;
    if_a.row_idx   = r;
    cycle();
    if_a.sad_valid = 1'b0;
  endtask

  bit          pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [7:0]  g0  [4] = '{8'd100, 8'd90, 8'd80, 8'd70};
  logic [7:0]  g1  [4] = '{8'd9, 8'd8, 8'd7, 8'd6};

  initial begin
    if_a.start = 1'b0; if_a.abort = 1'b0; if_a.sad_valid = 1'b0;
    if_a.sad_in = '0;  if_a.col_idx = '0; if_a.row_idx = '0;
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;

    // Reset state
    check("rst_busy", 64'(if_a.busy), 64'd0);
    check("rst_done", 64'(if_a.done), 64'd0);
    check("rst_cnt",  64'(if_a.cand_count), 64'd0);
    check("rst_sad",  64'(if_a.best_sad), 64'hFFFF);
    check("rst_col",  64'(if_a.best_col), 64'd0);
    check("rst_row",  64'(if_a.best_row), 64'd0);

    // Basic search and tie policy
    do_start();
    check("basic_busy", 64'(if_a.busy), 64'd1);
    check("basic_cnt0", 64'(if_a.cand_count), 64'd0);
    check("basic_sad_hold", 64'(if_a.best_sad), 64'hFFFF);
    feed(8'd40, 8'd10, 5'd0, 7'd0);
    feed(8'd30, 8'd20, 5'd1, 7'd0);
    feed(8'd30, 8'd5,  5'd0, 7'd1);
    check("basic_done_early", 64'(if_a.done), 64'd0);
    feed(8'd50, 8'd5,  5'd1, 7'd1);
    check("basic_done",  64'(if_a.done), 64'd1);
    check("basic_busy0", 64'(if_a.busy), 64'd0);
    check("basic_cnt",   64'(if_a.cand_count), 64'd4);
    check("basic_sad",   64'(if_a.best_sad), 64'h051E);
    check("basic_col",   64'(if_a.best_col), {54'd0, 5'd0, 5'd1});
    check("basic_row",   64'(if_a.best_row), {50'd0, 7'd1, 7'd0});
    check("tie_sad",     64'(if_b.best_sad), 64'h051E);
    check("tie_col",     64'(if_b.best_col), {54'd0, 5'd1, 5'd0});
    check("tie_row",     64'(if_b.best_row), {50'd0, 7'd1, 7'd1});
    check("tie_done",    64'(if_b.done), 64'd1);
    cycle();
    check("basic_done_pulse", 64'(if_a.done), 64'd0);
    check("basic_idle_busy",  64'(if_a.busy), 64'd0);
    check("basic_cnt_hold",   64'(if_a.cand_count), 64'd4);

    // All-ones: first candidate must still be loaded
    do_start();
    feed(8'd255, 8'd255, 5'd0, 7'd0);
    feed(8'd255, 8'd255, 5'd1, 7'd0);
    feed(8'd255, 8'd255, 5'd0, 7'd1);
    feed(8'd255, 8'd255, 5'd1, 7'd1);
    check("ones_done", 64'(if_a.done), 64'd1);
    check("ones_sad",  64'(if_a.best_sad), 64'hFFFF);
    check("ones_col",  64'(if_a.best_col), 64'd0);
    check("ones_row",  64'(if_a.best_row), 64'd0);
    cycle();

    // Gaps in sad_valid and a start pulse mid-scan
    do_start();
    begin
      int k = 0;
      for (int i = 0; i < 7; i++) begin
        if (pat[i]) begin
          feed(g0[k], g1[k], 5'(k), 7'd0);
          k++;
        end else begin
          if (i == 2) if_a.start = 1'b1;
          cycle();
          if_a.start = 1'b0;
        end
        check($sformatf("gap_cnt_%0d", i),  64'(if_a.cand_count), 64'(k));
        check($sformatf("gap_done_%0d", i), 64'(if_a.done), (i == 6) ? 64'd1 : 64'd0);
        check($sformatf("gap_busy_%0d", i), 64'(if_a.busy), (i == 6) ? 64'd0 : 64'd1);
      end
    end
    check("gap_sad", 64'(if_a.best_sad), 64'h0646);
    check("gap_col", 64'(if_a.best_col), {54'd0, 5'd3, 5'd3});
    cycle();
    check("gap_no_restart", 64'(if_a.busy), 64'd0);
    check("gap_done_count", 64'(done_seen), 64'd3);

    // Abort after two candidates; abort-cycle candidate is dropped
    do_start();
    feed(8'd12, 8'd3, 5'd1, 7'd1);
    feed(8'd11, 8'd4, 5'd2, 7'd2);
    if_a.abort = 1'b1;
    feed(8'd1, 8'd1, 5'd5, 7'd5);
    if_a.abort = 1'b0;
    check("abort_busy", 64'(if_a.busy), 64'd0);
    check("abort_done", 64'(if_a.done), 64'd0);
    check("abort_cnt",  64'(if_a.cand_count), 64'd2);
    check("abort_sad",  64'(if_a.best_sad), 64'h030B);
    check("abort_col",  64'(if_a.best_col), {54'd0, 5'd1, 5'd2});
    check("abort_row",  64'(if_a.best_row), {50'd0, 7'd1, 7'd2});
    cycle();
    check("abort_no_done", 64'(if_a.done), 64'd0);
    if_a.start = 1'b1;
    if_a.abort = 1'b1;
    cycle();
    if_a.start = 1'b0;
    if_a.abort = 1'b0;
    check("abort_start_idle", 64'(if_a.busy), 64'd0);
    do_start();
    check("restart_busy", 64'(if_a.busy), 64'd1);
    feed(8'd20, 8'd20, 5'd0, 7'd0);
    feed(8'd21, 8'd19, 5'd1, 7'd0);
    feed(8'd22, 8'd18, 5'd2, 7'd0);
    feed(8'd23, 8'd17, 5'd3, 7'd0);
    check("restart_done", 64'(if_a.done), 64'd1);
    check("restart_cnt",  64'(if_a.cand_count), 64'd4);
    check("restart_sad",  64'(if_a.best_sad), 64'h1114);
    cycle();
    check("abort_done_count", 64'(done_seen), 64'd4);

    // Reset mid-scan after three candidates
    do_start();
    feed(8'd50, 8'd50, 5'd1, 7'd2);
    feed(8'd40, 8'd40, 5'd2, 7'd3);
    feed(8'd30, 8'd30, 5'd3, 7'd4);
    rst = 1'b1;
    feed(8'd1, 8'd1, 5'd4, 7'd5);
    rst = 1'b0;
    check("mrst_busy", 64'(if_a.busy), 64'd0);
    check("mrst_done", 64'(if_a.done), 64'd0);
    check("mrst_sad",  64'(if_a.best_sad), 64'hFFFF);
    check("mrst_col",  64'(if_a.best_col), 64'd0);
    check("mrst_row",  64'(if_a.best_row), 64'd0);
    check("mrst_cnt",  64'(if_a.cand_count), 64'd0);
    feed(8'd1, 8'd1, 5'd4, 7'd5);
    check("mrst_ign_cnt", 64'(if_a.cand_count), 64'd0);
    check("mrst_ign_sad", 64'(if_a.best_sad), 64'hFFFF);
    cycle();
    check("mrst_done_count", 64'(done_seen), 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sad_min_mv_selector.md
SAD_MIN_MV_SELECTOR -- requirements
Module: sad_min_mv_selector

Interface
REQ-001 Parameter NUM_PART, default 16, number of partitions whose SADs are tracked in parallel.
REQ-002 Parameter SAD_W, default 16, width of one partition SAD, unsigned.
REQ-003 Parameter COL_W, default 5, width of the search column index.
REQ-004 Parameter ROW_W, default 7, width of the search row index.
REQ-005 Parameter NUM_CAND, default 4096, number of candidates per search (1 to 2^(COL_W+ROW_W)).
REQ-006 Parameter TIE_LAST, default 0: 0 keeps the earliest minimum, 1 keeps the latest.
REQ-007 clk  in  1  clock; all state updates on the rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 start  in  1  begins a search when the block is idle.
REQ-010 abort  in  1  terminates the current search without done.
REQ-011 sad_valid  in  1  sad_in, col_idx and row_idx carry one candidate this cycle.
REQ-012 sad_in  in  NUM_PART*SAD_W  candidate SADs; partition p occupies bits [p*SAD_W +: SAD_W].
REQ-013 col_idx  in  COL_W  search column of the candidate.
REQ-014 row_idx  in  ROW_W  search row of the candidate.
REQ-015 busy  out  1  high while in state SCAN.
REQ-016 done  out  1  one-cycle pulse when the search completes.
REQ-017 best_sad  out  NUM_PART*SAD_W  per-partition minimum SAD, packed like sad_in.
REQ-018 best_col  out  NUM_PART*COL_W  per-partition column of the minimum.
REQ-019 best_row  out  NUM_PART*ROW_W  per-partition row of the minimum.
REQ-020 cand_count  out  COL_W+ROW_W+1  number of candidates accepted in the current or last search.

Function
REQ-021 FSM states: IDLE, SCAN, DONE.
REQ-022 IDLE: start=1 clears cand_count to 0, arms the first-candidate flag and moves to SCAN next cycle; best_* hold their previous values until the first candidate arrives.
REQ-023 SCAN: each cycle with sad_valid=1 increments cand_count by 1 and evaluates every partition in parallel in the same cycle.
REQ-024 First candidate of a search: all partitions load sad/col/row unconditionally, including SAD = all-ones.
REQ-025 Later candidates: partition p updates when sad < best (TIE_LAST=0) or sad <= best (TIE_LAST=1); otherwise p holds.
REQ-026 Comparisons are unsigned, full SAD_W width; no saturation or truncation.
REQ-027 When the accepted candidate makes cand_count equal NUM_CAND, the next state is DONE; best_* are final in that same edge.
REQ-028 DONE lasts exactly one cycle with done=1, then returns to IDLE; done is asserted the cycle after the last sad_valid.
REQ-029 sad_valid is ignored in IDLE and DONE; start is ignored in SCAN and DONE.
REQ-030 abort=1 in SCAN returns to IDLE next cycle with no done pulse; best_* and cand_count hold the values from before that cycle; sad_valid in the abort cycle is dropped.
REQ-031 abort and start together in IDLE: abort wins and the state stays IDLE.
REQ-032 busy=1 exactly when the state is SCAN; outputs are registered.

Reset
REQ-033 rst=1 forces IDLE at the next edge from any state, including mid-SCAN and DONE, and overrides start and abort.
REQ-034 Reset values: busy=0, done=0, cand_count=0, best_sad all-ones, best_col=0, best_row=0, first-candidate flag cleared.

Verification (NUM_PART=2, SAD_W=8, NUM_CAND=4 unless stated)
REQ-035 Basic: start; feed p0 SADs 40,30,30,50 and p1 SADs 10,20,5,5 at (c,r)=(0,0),(1,0),(0,1),(1,1) -> done one cycle after the 4th valid; best_sad p0=30 @(1,0), p1=5 @(0,1); cand_count=4.
REQ-036 Ties: same stimulus with TIE_LAST=1 -> p0=30 @(0,1), p1=5 @(1,1).
REQ-037 All-ones: every SAD=255 -> best_sad=255 @(0,0) for both partitions (first candidate loaded).
REQ-038 Gaps and ignores: sad_valid toggles 1,0,0,1,1,0,1 and start pulses mid-SCAN -> only 4 candidates counted, no restart, done once.
REQ-039 Abort: abort after 2 candidates -> no done, busy=0 next cycle, cand_count=2; a new start then completes normally.
REQ-040 Reset mid-SCAN: rst after 3 candidates -> next cycle busy=0, done=0, best_sad=0xFF, best_col=0, best_row=0, cand_count=0; the 4th valid is ignored.
